// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   IF-stage fetch controller. Drives the PC register (next_pc/pc_write),
//   runs the imem request/ack handshake and arbitrates redirect sources
//   (exc > eret > br_taken > jump) against load-use stall and sequential
//   +4 fetch. Raises a sticky imem_err when an ack does not arrive within
//   ACK_TIMEOUT request cycles.
//
// Ports
//   clock, reset           rising-edge clock, async active-high reset
//   pc                     current PC from the PC register
//   next_pc, pc_write      PC register load value and enable
//   imem_req, imem_ack     instruction-memory fetch handshake
//   stall_id               load-use hazard, IF/ID must not advance
//   exc                    exception pulse (target EXC_VECTOR)
//   eret, epc              exception return pulse and address
//   br_taken, br_target    taken-branch pulse and target
//   jump, jump_target      jump pulse and target
//   if_valid, flush_if     IF/ID latch enable and wrong-path flush
//   imem_err               sticky ack-timeout error (registered)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pc_write,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        stall_id,
    input  logic        exc,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        if_valid,
    output logic        flush_if,
    output logic        imem_err
);

    localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] wait_cnt, wait_d;
    logic          pend_valid, pend_valid_d;
    logic [1:0]    pend_prio, pend_prio_d;
    logic [31:0]   pend_pc, pend_pc_d;
    logic          err_set;

    // Redirect arbitration; lower redir_prio value means higher priority.
    logic        redir;
    logic [1:0]  redir_prio;
    logic [31:0] redir_raw;
    logic [31:0] redir_pc;

    always_comb begin
        redir      = exc | eret | br_taken | jump;
        redir_prio = 2'd3;
        redir_raw  = jump_target;
        if (exc) begin
            redir_prio = 2'd0;
            redir_raw  = EXC_VECTOR;
        end else if (eret) begin
            redir_prio = 2'd1;
            redir_raw  = epc;
        end else if (br_taken) begin
            redir_prio = 2'd2;
            redir_raw  = br_target;
        end
        redir_pc = {redir_raw[31:2], 2'b00};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_prio  <= '0;
            pend_pc    <= '0;
            imem_err   <= 1'b0;
        end else begin
            state      <= state_d;
            wait_cnt   <= wait_d;
            pend_valid <= pend_valid_d;
            pend_prio  <= pend_prio_d;
            pend_pc    <= pend_pc_d;
            imem_err   <= imem_err | err_set;
        end
    end

    always_comb begin
        state_d      = state;
        wait_d       = wait_cnt;
        pend_valid_d = pend_valid;
        pend_prio_d  = pend_prio;
        pend_pc_d    = pend_pc;
        err_set      = 1'b0;
        next_pc      = RESET_PC;
        pc_write     = 1'b0;
        imem_req     = 1'b0;
        if_valid     = 1'b0;
        flush_if     = 1'b0;

        unique case (state)
            IDLE: state_d = REQ;

            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    wait_d       = '0;
                    // Any ack consumes the pending redirect: either it is
                    // applied now or a fresher redirect supersedes it.
                    pend_valid_d = 1'b0;
                    if (redir) begin
                        pc_write = 1'b1;
                        next_pc  = redir_pc;
                        flush_if = 1'b1;
                    end else if (pend_valid) begin
                        pc_write = 1'b1;
                        next_pc  = pend_pc;
                        flush_if = 1'b1;
                    end else if (stall_id) begin
                        state_d = HOLD;
                    end else begin
                        pc_write = 1'b1;
                        next_pc  = pc + 32'd4;
                        if_valid = 1'b1;
                    end
                end else begin
                    // A redirect seen while waiting is remembered; only a
                    // strictly higher-priority one may replace it.
                    if (redir && (!pend_valid || (redir_prio < pend_prio))) begin
                        pend_valid_d = 1'b1;
                        pend_prio_d  = redir_prio;
                        pend_pc_d    = redir_pc;
                    end
                    if (wait_cnt == WAIT_LAST) begin
                        state_d = ERROR;
                        err_set = 1'b1;
                    end else begin
                        wait_d = wait_cnt + 1'b1;
                    end
                end
            end

            HOLD: begin
                if (redir) begin
                    pc_write = 1'b1;
                    next_pc  = redir_pc;
                    flush_if = 1'b1;
                    state_d  = REQ;
                end else if (!stall_id) begin
                    state_d = REQ;
                end
            end

            ERROR: ;

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios pinned with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model that also owns the PC register.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR  = 32'h8000_0180;
    localparam int          ACK_TIMEOUT = 16;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_HOLD = 2;
    localparam int P_ERR  = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = RESET_PC;
    logic [31:0] next_pc;
    logic        pc_write, imem_req, if_valid, flush_if, imem_err;
    logic        imem_ack = 1'b0, stall_id = 1'b0;
    logic        exc = 1'b0, eret = 1'b0, br_taken = 1'b0, jump = 1'b0;
    logic [31:0] epc = '0, br_target = '0, jump_target = '0;

    fetch_sequencer #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .next_pc    (next_pc),
        .pc_write   (pc_write),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .stall_id   (stall_id),
        .exc        (exc),
        .eret       (eret),
        .epc        (epc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jump       (jump),
        .jump_target(jump_target),
        .if_valid   (if_valid),
        .flush_if   (flush_if),
        .imem_err   (imem_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    // Stimulus staged for the next cycle
    logic        n_reset = 1'b1, n_ack = 1'b0, n_stall = 1'b0;
    logic        n_exc = 1'b0, n_eret = 1'b0, n_br = 1'b0, n_jump = 1'b0;
    logic [31:0] n_epc = '0, n_brt = '0, n_jt = '0;

    // Behavioural model
    int          m_phase;
    int          m_wait;
    bit          m_pv;
    int          m_pprio;
    logic [31:0] m_paddr;
    bit          m_err;
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_wait  = 0;
        m_pv    = 0;
        m_pprio = 0;
        m_paddr = '0;
        m_err   = 0;
        m_pc    = RESET_PC;
    endtask

    task automatic model_check();
        logic [31:0] tgt [4];
        bit          req [4];
        int          win;
        logic [31:0] e_np;
        bit          e_pw, e_req, e_iv, e_fl;
        e_np  = RESET_PC;
        e_pw  = 0;
        e_req = 0;
        e_iv  = 0;
        e_fl  = 0;
        req = '{exc, eret, br_taken, jump};
        tgt = '{EXC_VECTOR, epc, br_target, jump_target};
        win = -1;
        for (int i = 0; i < 4; i++)
            if (req[i] && win < 0) win = i;

        if (!reset) begin
            case (m_phase)
                P_IDLE: m_phase = P_REQ;
                P_REQ: begin
                    e_req = 1;
                    if (imem_ack) begin
                        m_wait = 0;
                        if (win >= 0) begin
                            e_pw = 1; e_fl = 1; e_np = tgt[win] & 32'hFFFF_FFFC;
                        end else if (m_pv) begin
                            e_pw = 1; e_fl = 1; e_np = m_paddr;
                        end else if (stall_id) begin
                            m_phase = P_HOLD;
                        end else begin
                            e_pw = 1; e_iv = 1; e_np = m_pc + 32'd4;
                        end
                        m_pv = 0;
                    end else begin
                        if (win >= 0 && (!m_pv || win < m_pprio)) begin
                            m_pv    = 1;
                            m_pprio = win;
                            m_paddr = tgt[win] & 32'hFFFF_FFFC;
                        end
                        if (m_wait == ACK_TIMEOUT - 1) m_phase = P_ERR;
                        else m_wait++;
                    end
                end
                P_HOLD: begin
                    if (win >= 0) begin
                        e_pw = 1; e_fl = 1; e_np = tgt[win] & 32'hFFFF_FFFC;
                        m_phase = P_REQ;
                    end else if (!stall_id) begin
                        m_phase = P_REQ;
                    end
                end
                default: ;
            endcase
        end

        chk("pc_write", {31'd0, pc_write}, {31'd0, e_pw});
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("if_valid", {31'd0, if_valid}, {31'd0, e_iv});
        chk("flush_if", {31'd0, flush_if}, {31'd0, e_fl});
        chk("imem_err", {31'd0, imem_err}, {31'd0, m_err});
        if (e_pw || m_phase == P_IDLE || reset) chk("next_pc", next_pc, e_np);

        // error flag is registered: becomes visible from the next cycle
        if (m_phase == P_ERR) m_err = 1;
        if (e_pw) m_pc = e_np;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        reset       = n_reset;
        imem_ack    = n_ack;
        stall_id    = n_stall;
        exc         = n_exc;
        eret        = n_eret;
        br_taken    = n_br;
        jump        = n_jump;
        epc         = n_epc;
        br_target   = n_brt;
        jump_target = n_jt;
        if (reset) model_reset();
        pc = m_pc;
        #3;
        model_check();
    endtask

    task automatic clr();
        n_ack = 0; n_stall = 0; n_exc = 0; n_eret = 0; n_br = 0; n_jump = 0;
    endtask

    initial begin
        int ack_pct;
        model_reset();

        // reset state
        cycle();
        cycle();
        chk("rst next_pc", next_pc, 32'h0040_0000);
        n_reset = 0;
        cycle();                               // IDLE
        chk("idle req", {31'd0, imem_req}, 32'd0);

        // T1: ack every request cycle
        n_ack = 1;
        cycle();
        chk("T1 np0", next_pc, 32'h0040_0004);
        chk("T1 pw0", {31'd0, pc_write}, 32'd1);
        cycle();
        chk("T1 np1", next_pc, 32'h0040_0008);

        // T2: branch during wait, ack three cycles late
        clr();
        n_br = 1; n_brt = 32'h0040_0100;
        cycle();
        n_br = 0;
        cycle();
        cycle();
        n_ack = 1;
        cycle();
        chk("T2 np", next_pc, 32'h0040_0100);
        chk("T2 flush", {31'd0, flush_if}, 32'd1);
        chk("T2 ifv", {31'd0, if_valid}, 32'd0);

        // T3: exc beats jump
        clr();
        n_ack = 1; n_exc = 1; n_jump = 1; n_jt = 32'h0040_0200;
        cycle();
        chk("T3 np", next_pc, 32'h8000_0180);
        chk("T3 flush", {31'd0, flush_if}, 32'd1);

        // T4: stall at ack, hold, refetch same pc
        clr();
        n_ack = 1; n_stall = 1;
        cycle();
        chk("T4 pw", {31'd0, pc_write}, 32'd0);
        n_ack = 0;
        cycle();
        chk("T4 hold req", {31'd0, imem_req}, 32'd0);
        n_stall = 0;
        cycle();
        n_ack = 1;
        cycle();
        chk("T4 refetch np", next_pc, 32'h8000_0184);

        // T5: ack timeout
        clr();
        repeat (ACK_TIMEOUT) cycle();
        cycle();
        chk("T5 err", {31'd0, imem_err}, 32'd1);
        chk("T5 req", {31'd0, imem_req}, 32'd0);
        n_reset = 1;
        cycle();
        chk("T5 rst err", {31'd0, imem_err}, 32'd0);
        n_reset = 0;
        cycle();

        // T6: wrap and target alignment
        m_pc  = 32'hFFFF_FFFC;
        n_ack = 1;
        cycle();
        chk("T6 wrap", next_pc, 32'h0000_0000);
        n_br = 1; n_brt = 32'h0040_0103;
        cycle();
        chk("T6 align", next_pc, 32'h0040_0100);
        clr();

        // Randomized traffic
        ack_pct = 60;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: ack_pct = 4;
                    1: ack_pct = 30;
                    2: ack_pct = 70;
                    default: ack_pct = 100;
                endcase
            end
            n_reset = ($urandom_range(0, 999) < ((m_phase == P_ERR) ? 40 : 5));
            n_ack   = ($urandom_range(0, 99) < ack_pct);
            n_stall = ($urandom_range(0, 99) < 25);
            n_exc   = ($urandom_range(0, 99) < 5);
            n_eret  = ($urandom_range(0, 99) < 7);
            n_br    = ($urandom_range(0, 99) < 10);
            n_jump  = ($urandom_range(0, 99) < 10);
            n_epc   = $urandom;
            n_brt   = $urandom;
            n_jt    = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
